// File: rtl/host_frame_receiver.sv
// Host frame receiver: assembles SYNC/control/4 data/XOR-checksum frames from a
// UART byte stream and holds each valid frame until the consumer acknowledges it.
module host_frame_receiver #(
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic        masterClock,
   input  logic        reset,
   input  logic        rxValid,
   input  logic [7:0]  rxByte,
   input  logic        clearDR,
   output logic        dataReceived,
   output logic [7:0]  control,
   output logic [31:0] inputData,
   output logic        frameError,
   output logic        overrun,
   output logic        busy
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned IDX_W  = 2;
   localparam int unsigned CNT_W  = 20;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CTRL     = 3'd1,
      DATA     = 3'd2,
      CSUM     = 3'd3,
      HOLD     = 3'd4,
      WAIT_CLR = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [BYTE_W-1:0]   ctrl_sh_q, ctrl_sh_d;
   logic [DATA_W-1:0]   data_sh_q, data_sh_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    tmo_q, tmo_d;
   logic [BYTE_W-1:0]   control_q, control_d;
   logic [DATA_W-1:0]   input_data_q, input_data_d;
   logic                data_received_q, data_received_d;
   logic                frame_error_q, frame_error_d;
   logic                overrun_q, overrun_d;
   logic                busy_q, busy_d;

   logic                in_frame;
   logic                timeout_hit;
   logic [BYTE_W-1:0]   csum_exp;

   assign in_frame    = (state_q == CTRL) || (state_q == DATA) || (state_q == CSUM);
   assign timeout_hit = in_frame && !rxValid && (tmo_q == TMO_LAST);
   assign csum_exp    = ctrl_sh_q ^ data_sh_q[7:0] ^ data_sh_q[15:8]
                      ^ data_sh_q[23:16] ^ data_sh_q[31:24];

   // Next-state and next-output logic
   always_comb begin
      state_d         = state_q;
      ctrl_sh_d       = ctrl_sh_q;
      data_sh_d       = data_sh_q;
      idx_d           = idx_q;
      control_d       = control_q;
      input_data_d    = input_data_q;
      data_received_d = data_received_q;
      frame_error_d   = 1'b0;
      overrun_d       = 1'b0;
      tmo_d           = '0;

      if (in_frame && !rxValid) begin
         tmo_d = tmo_q + CNT_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (rxValid && (rxByte == SYNC_BYTE)) begin
               state_d = CTRL;
            end
         end
         CTRL: begin
            if (rxValid) begin
               ctrl_sh_d = rxByte;
               idx_d     = '0;
               state_d   = DATA;
            end else if (timeout_hit) begin
               frame_error_d = 1'b1;
               state_d       = IDLE;
            end
         end
         DATA: begin
            if (rxValid) begin
               unique case (idx_q)
                  2'd0:    data_sh_d[7:0]   = rxByte;
                  2'd1:    data_sh_d[15:8]  = rxByte;
                  2'd2:    data_sh_d[23:16] = rxByte;
                  default: data_sh_d[31:24] = rxByte;
               endcase
               idx_d = idx_q + IDX_W'(1);
               if (idx_q == IDX_W'(3)) begin
                  state_d = CSUM;
               end
            end else if (timeout_hit) begin
               frame_error_d = 1'b1;
               state_d       = IDLE;
            end
         end
         CSUM: begin
            if (rxValid) begin
               if (rxByte == csum_exp) begin
                  control_d       = ctrl_sh_q;
                  input_data_d    = data_sh_q;
                  data_received_d = 1'b1;
                  state_d         = HOLD;
               end else begin
                  frame_error_d = 1'b1;
                  state_d       = IDLE;
               end
            end else if (timeout_hit) begin
               frame_error_d = 1'b1;
               state_d       = IDLE;
            end
         end
         HOLD: begin
            overrun_d = rxValid;
            if (clearDR) begin
               data_received_d = 1'b0;
               state_d         = WAIT_CLR;
            end
         end
         WAIT_CLR: begin
            // Bytes are still dropped here so a frame cannot land before clearDR falls
            overrun_d = rxValid;
            if (!clearDR) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers
   always_ff @(posedge masterClock) begin
      if (reset) begin
         state_q         <= IDLE;
         ctrl_sh_q       <= '0;
         data_sh_q       <= '0;
         idx_q           <= '0;
         tmo_q           <= '0;
         control_q       <= '0;
         input_data_q    <= '0;
         data_received_q <= 1'b0;
         frame_error_q   <= 1'b0;
         overrun_q       <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         ctrl_sh_q       <= ctrl_sh_d;
         data_sh_q       <= data_sh_d;
         idx_q           <= idx_d;
         tmo_q           <= tmo_d;
         control_q       <= control_d;
         input_data_q    <= input_data_d;
         data_received_q <= data_received_d;
         frame_error_q   <= frame_error_d;
         overrun_q       <= overrun_d;
         busy_q          <= busy_d;
      end
   end

   assign dataReceived = data_received_q;
   assign control      = control_q;
   assign inputData    = input_data_q;
   assign frameError   = frame_error_q;
   assign overrun      = overrun_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_host_frame_receiver.sv
// Directed bench for host_frame_receiver with a short timeout so expiry is reachable.
module tb_host_frame_receiver;

   logic        masterClock = 1'b0;
   logic        reset;
   logic        rxValid;
   logic [7:0]  rxByte;
   logic        clearDR;
   logic        dataReceived;
   logic [7:0]  control;
   logic [31:0] inputData;
   logic        frameError;
   logic        overrun;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   host_frame_receiver #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(10)) dut (
      .masterClock (masterClock),
      .reset       (reset),
      .rxValid     (rxValid),
      .rxByte      (rxByte),
      .clearDR     (clearDR),
      .dataReceived(dataReceived),
      .control     (control),
      .inputData   (inputData),
      .frameError  (frameError),
      .overrun     (overrun),
      .busy        (busy)
   );

   always #5 masterClock = ~masterClock;

   task automatic step();
      @(posedge masterClock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rxValid = 1'b1;
      rxByte  = b;
      step();
      rxValid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [31:0] d, input logic [7:0] cs);
      send_byte(8'hA5);
      send_byte(c);
      send_byte(d[7:0]);
      send_byte(d[15:8]);
      send_byte(d[23:16]);
      send_byte(d[31:24]);
      send_byte(cs);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset   = 1'b1;
      rxValid = 1'b0;
      rxByte  = 8'h00;
      clearDR = 1'b0;
      step(); step(); step();
      check("rst_dr",    32'(dataReceived), 32'd0);
      check("rst_ctrl",  32'(control),      32'd0);
      check("rst_data",  inputData,         32'd0);
      check("rst_ferr",  32'(frameError),   32'd0);
      check("rst_ovr",   32'(overrun),      32'd0);
      check("rst_busy",  32'(busy),         32'd0);
      reset = 1'b0;
      step();

      // Good frame
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h44);
      send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
      check("f1_dr_pre",  32'(dataReceived), 32'd0);
      check("f1_busy",    32'(busy),         32'd1);
      send_byte(8'h45);
      check("f1_dr",      32'(dataReceived), 32'd1);
      check("f1_ctrl",    32'(control),      32'h01);
      check("f1_data",    inputData,         32'h11223344);
      clearDR = 1'b1; step();
      check("f1_clr_dr",  32'(dataReceived), 32'd0);
      check("f1_clr_bsy", 32'(busy),         32'd1);
      clearDR = 1'b0; step();
      check("f1_idle",    32'(busy),         32'd0);

      // Bad checksum
      send_frame(8'h01, 32'h11223344, 8'h46);
      check("f2_ferr",    32'(frameError),   32'd1);
      check("f2_dr",      32'(dataReceived), 32'd0);
      step();
      check("f2_ferr_1c", 32'(frameError),   32'd0);
      check("f2_busy",    32'(busy),         32'd0);
      check("f2_ctrl",    32'(control),      32'h01);

      // Garbage before a frame
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h7E);
      check("f3_gbusy",   32'(busy),         32'd0);
      send_frame(8'h01, 32'h11223344, 8'h45);
      check("f3_dr",      32'(dataReceived), 32'd1);
      check("f3_data",    inputData,         32'h11223344);
      clearDR = 1'b1; step(); clearDR = 1'b0; step();

      // Timeout after A5 01
      send_byte(8'hA5); send_byte(8'h01);
      for (int i = 0; i < 9; i++) step();
      check("f4_pre_ferr", 32'(frameError), 32'd0);
      check("f4_pre_busy", 32'(busy),       32'd1);
      step();
      check("f4_ferr",    32'(frameError),  32'd1);
      check("f4_busy",    32'(busy),        32'd0);
      step();
      check("f4_ferr_1c", 32'(frameError),  32'd0);
      send_frame(8'h02, 32'hEFBEADDE, 8'h20);
      check("f4_dr",      32'(dataReceived), 32'd1);
      check("f4_ctrl",    32'(control),      32'h02);
      check("f4_data",    inputData,         32'hEFBEADDE);

      // Overrun in HOLD, clearDR held high with a frame arriving
      send_byte(8'h5A);
      check("f5_ovr",     32'(overrun),      32'd1);
      check("f5_dr",      32'(dataReceived), 32'd1);
      check("f5_data",    inputData,         32'hEFBEADDE);
      step();
      check("f5_ovr_1c",  32'(overrun),      32'd0);
      clearDR = 1'b1; step();
      check("f5_clr_dr",  32'(dataReceived), 32'd0);
      send_byte(8'hA5);
      check("f5_ovr2",    32'(overrun),      32'd1);
      send_byte(8'h01); send_byte(8'h44); send_byte(8'h33);
      send_byte(8'h22); send_byte(8'h11); send_byte(8'h45);
      check("f5_noreas",  32'(dataReceived), 32'd0);
      check("f5_ctrl",    32'(control),      32'h02);
      check("f5_wbusy",   32'(busy),         32'd1);
      clearDR = 1'b0; step();
      check("f5_idle",    32'(busy),         32'd0);
      check("f5_dr_end",  32'(dataReceived), 32'd0);

      // Byte arriving on the expiry cycle wins
      send_byte(8'hA5);
      for (int i = 0; i < 9; i++) step();
      send_byte(8'h01);
      check("f6_ferr",    32'(frameError),   32'd0);
      check("f6_busy",    32'(busy),         32'd1);
      send_byte(8'h44); send_byte(8'h33); send_byte(8'h22);
      send_byte(8'h11); send_byte(8'h45);
      check("f6_dr",      32'(dataReceived), 32'd1);
      check("f6_data",    inputData,         32'h11223344);
      clearDR = 1'b1; step(); clearDR = 1'b0; step();

      // Reset mid-frame
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h44);
      reset = 1'b1; step();
      check("f7_ctrl",    32'(control),      32'd0);
      check("f7_data",    inputData,         32'd0);
      check("f7_busy",    32'(busy),         32'd0);
      check("f7_ferr",    32'(frameError),   32'd0);
      reset = 1'b0; step();
      check("f7_ferr2",   32'(frameError),   32'd0);
      send_frame(8'h01, 32'h11223344, 8'h45);
      check("f7_dr",      32'(dataReceived), 32'd1);
      check("f7_ctrl2",   32'(control),      32'h01);
      check("f7_data2",   inputData,         32'h11223344);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/host_frame_receiver.md
HOST_FRAME_RECEIVER -- requirements
Module: host_frame_receiver

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, inter-byte timeout in masterClock cycles (range 2..2^20-1).
REQ-003 masterClock  input  1  sole operating clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rxValid  input  1  single-cycle strobe; rxByte valid this cycle (UART receiver output).
REQ-006 rxByte  input  8  received byte.
REQ-007 clearDR  input  1  consumer acknowledge; high = frame consumed, ready for next.
REQ-008 dataReceived  output  1  high = control/inputData hold a valid frame.
REQ-009 control  output  8  frame control byte.
REQ-010 inputData  output  32  frame data word.
REQ-011 frameError  output  1  one-cycle pulse on checksum mismatch or timeout.
REQ-012 overrun  output  1  one-cycle pulse when a byte is dropped while a frame is held.
REQ-013 busy  output  1  high while in any state other than IDLE.

Function
REQ-014 Frame format SHALL be: SYNC_BYTE, control, d0, d1, d2, d3, checksum; inputData = {d3,d2,d1,d0} (d0 first, LSB).
REQ-015 checksum SHALL equal control ^ d0 ^ d1 ^ d2 ^ d3 (8-bit XOR).
REQ-016 States SHALL be IDLE, CTRL, DATA, CSUM, HOLD, WAIT_CLR.
REQ-017 IDLE: rxValid with rxByte==SYNC_BYTE -> CTRL; any other byte silently ignored.
REQ-018 CTRL: rxValid -> capture control into shadow register, byte index = 0, -> DATA.
REQ-019 DATA: each rxValid captures byte at current index into shadow data; after index 3 -> CSUM; SYNC_BYTE value is treated as ordinary data here.
REQ-020 CSUM: rxValid with matching checksum -> copy shadows to control/inputData, dataReceived=1 next cycle, -> HOLD; mismatch -> frameError pulse, -> IDLE, outputs unchanged.
REQ-021 control/inputData SHALL change only on frame commit; stable at all other times.
REQ-022 HOLD: clearDR=1 -> dataReceived=0 next cycle, -> WAIT_CLR.
REQ-023 WAIT_CLR: clearDR=0 -> IDLE; dataReceived SHALL NOT reassert before clearDR returns low.
REQ-024 rxValid in HOLD or WAIT_CLR SHALL drop the byte and pulse overrun next cycle; state unchanged.
REQ-025 clearDR outside HOLD/WAIT_CLR SHALL be ignored.
REQ-026 Timeout counter (20 bits) SHALL clear on every accepted byte and on entry to CTRL, increment each cycle in CTRL/DATA/CSUM without rxValid.
REQ-027 Counter reaching TIMEOUT_CYCLES-1 with no rxValid SHALL pulse frameError, discard partial frame, -> IDLE.
REQ-028 rxValid in the same cycle as timeout expiry SHALL win: byte accepted, no error.
REQ-029 frameError and overrun SHALL be registered, high exactly one cycle per event.

Reset
REQ-030 reset=1 SHALL force state IDLE, dataReceived=0, control=0, inputData=0, frameError=0, overrun=0, busy=0, counter=0, shadows=0.
REQ-031 reset mid-frame or during HOLD SHALL discard all frame state; no error pulse issued.

Verification
REQ-032 Bytes A5 01 44 33 22 11 45 -> dataReceived=1 one cycle after last byte, control=8'h01, inputData=32'h11223344.
REQ-033 Bytes A5 01 44 33 22 11 46 -> one frameError pulse, dataReceived stays 0, busy=0 after.
REQ-034 Garbage 00 FF 7E then valid frame from 032 -> garbage ignored, frame delivered as in 032.
REQ-035 TIMEOUT_CYCLES=10, send A5 01 then idle 10 cycles -> frameError pulse, IDLE; next valid frame delivered.
REQ-036 During HOLD send byte 5A -> overrun pulse, outputs unchanged; clearDR=1 -> dataReceived=0 next cycle; hold clearDR high 5 cycles with new frame pending -> no reassert until clearDR=0.
REQ-037 Assert reset after A5 01 44 -> all outputs 0; subsequent full frame from 032 delivered correctly.
